// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared types and constants for the SPI register-access
// arbiter. Holds the frame FSM state encoding and the fixed byte values
// placed on the wire or returned to requesters.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_TX0  = 3'd1,
    S_TX1  = 3'd2,
    S_RX0  = 3'd3,
    S_RX1  = 3'd4,
    S_RESP = 3'd5
  } state_t;

  // Position of the read/write flag inside frame byte0.
  localparam int RW_BIT = 7;

  // Byte1 sent on reads (no write data to carry).
  localparam logic [7:0] READ_FILL = 8'h00;

  // Read data returned when an RX byte never arrives.
  localparam logic [7:0] TIMEOUT_DATA = 8'hFF;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
// Ports:
//   req       in  NUM_REQ  pending requests
//   pointer   in  IDX_W    index of the previous winner
//   grant     out NUM_REQ  one-hot winner (all zero when no request)
//   grant_idx out IDX_W    binary index of the winner (0 when none)
// The search starts one past the pointer and wraps, so the previous
// winner has the lowest priority. The pointer register lives in the parent.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   pointer,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic found;
  int   cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = (int'(pointer) + off) % NUM_REQ;
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_reg_arbiter.sv
// spi_reg_arbiter: shares one byte-stream SPI master among NUM_REQ
// register-access requesters. Each accepted request becomes a 2-byte frame
// {rw, addr[6:0]}, {wdata or 0x00}; RX byte1 comes back as read data.
// Ports:
//   aclk, aresetn           clock, synchronous active-low reset
//   req_valid/ready         per-requester handshake (ready = one-hot grant)
//   req_rw/addr/wdata       packed request fields, requester i at slice i
//   rsp_valid               one-cycle completion pulse to the owner
//   rsp_rdata, rsp_err      read data / timeout flag, valid with rsp_valid
//   m_axis_*                TX bytes to the SPI master
//   s_axis_*                RX bytes from the SPI master
//   busy                    frame in progress
//   stat_rx_stray           pulse: RX byte arrived outside an RX state
// Handshakes: a transfer happens on any cycle where valid and ready are both
// high; a source holds valid and its payload stable until that cycle.
module spi_reg_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ-1:0]   req_rw,
  input  logic [NUM_REQ*7-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [7:0]           rsp_rdata,
  output logic                 rsp_err,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  input  logic [7:0]           s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic                 busy,
  output logic                 stat_rx_stray
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(NUM_REQ - 1);

  state_t             state_q, state_n;
  logic [IDX_W-1:0]   ptr_q, ptr_n;
  logic [IDX_W-1:0]   g_q, g_n;
  logic               rw_q, rw_n;
  logic [6:0]         addr_q, addr_n;
  logic [7:0]         wdata_q, wdata_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [7:0]         rdata_q, rdata_n;
  logic               err_q, err_n;
  logic [7:0]         tx_data_n;
  logic               tx_valid_n;
  logic               stray_n;
  logic               accept;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req       (req_valid),
    .pointer   (ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  // The grant is only offered while idle; the arbiter only grants a valid
  // requester, so any grant bit in S_IDLE is an accepted request.
  assign req_ready = (state_q == S_IDLE) ? arb_grant : '0;
  assign accept    = (state_q == S_IDLE) && (|arb_grant);

  always_comb begin
    state_n    = state_q;
    ptr_n      = ptr_q;
    g_n        = g_q;
    rw_n       = rw_q;
    addr_n     = addr_q;
    wdata_n    = wdata_q;
    cnt_n      = cnt_q;
    rdata_n    = rdata_q;
    err_n      = err_q;
    tx_data_n  = '0;
    tx_valid_n = 1'b0;
    stray_n    = s_axis_tvalid && (state_q != S_RX0) && (state_q != S_RX1);

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          g_n     = arb_idx;
          ptr_n   = arb_idx;
          rw_n    = req_rw[arb_idx];
          addr_n  = req_addr[7*int'(arb_idx) +: 7];
          wdata_n = req_wdata[8*int'(arb_idx) +: 8];
          err_n   = 1'b0;
          state_n = S_TX0;
        end
      end
      S_TX0: begin
        if (m_axis_tready) state_n = S_TX1;
      end
      S_TX1: begin
        if (m_axis_tready) begin
          cnt_n   = '0;
          state_n = S_RX0;
        end
      end
      S_RX0: begin
        // A byte arriving on the last wait cycle still wins over the timeout.
        if (s_axis_tvalid) begin
          cnt_n   = '0;
          state_n = S_RX1;
        end else if (cnt_q == CNT_MAX) begin
          rdata_n = TIMEOUT_DATA;
          err_n   = 1'b1;
          state_n = S_RESP;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      S_RX1: begin
        if (s_axis_tvalid) begin
          cnt_n   = '0;
          rdata_n = s_axis_tdata;
          err_n   = 1'b0;
          state_n = S_RESP;
        end else if (cnt_q == CNT_MAX) begin
          rdata_n = TIMEOUT_DATA;
          err_n   = 1'b1;
          state_n = S_RESP;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    // TX outputs are registered from the next state, so tvalid stays high
    // without a gap from the first byte through the second.
    case (state_n)
      S_TX0: begin
        tx_valid_n                = 1'b1;
        tx_data_n[RW_BIT]         = rw_n;
        tx_data_n[RW_BIT-1:0]     = addr_n;
      end
      S_TX1: begin
        tx_valid_n = 1'b1;
        tx_data_n  = rw_n ? READ_FILL : wdata_n;
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) state_q <= S_IDLE;
    else          state_q <= state_n;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ptr_q         <= PTR_RST;
      g_q           <= '0;
      rw_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      cnt_q         <= '0;
      rdata_q       <= '0;
      err_q         <= 1'b0;
      rsp_valid     <= '0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      s_axis_tready <= 1'b1;
      busy          <= 1'b0;
      stat_rx_stray <= 1'b0;
    end else begin
      ptr_q         <= ptr_n;
      g_q           <= g_n;
      rw_q          <= rw_n;
      addr_q        <= addr_n;
      wdata_q       <= wdata_n;
      cnt_q         <= cnt_n;
      rdata_q       <= rdata_n;
      err_q         <= err_n;
      rsp_valid     <= (state_n == S_RESP) ? (NUM_REQ'(1) << g_n) : '0;
      if (state_n == S_RESP) begin
        rsp_rdata <= rdata_n;
        rsp_err   <= err_n;
      end
      m_axis_tdata  <= tx_data_n;
      m_axis_tvalid <= tx_valid_n;
      // Every RX byte is accepted; bytes outside an RX state are dropped.
      s_axis_tready <= 1'b1;
      busy          <= (state_n != S_IDLE);
      stat_rx_stray <= stray_n;
    end
  end

endmodule

// File: tb/tb_spi_reg_arbiter.sv
// tb_spi_reg_arbiter: directed bench for spi_reg_arbiter with a small SPI
// master model that echoes one RX byte per TX byte a few cycles later.
module tb_spi_reg_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 1024;

  // ---------------- clock / reset ----------------
  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  logic [NUM_REQ-1:0]   req_valid, req_ready, req_rw, rsp_valid;
  logic [NUM_REQ*7-1:0] req_addr;
  logic [NUM_REQ*8-1:0] req_wdata;
  logic [7:0]           rsp_rdata, m_axis_tdata, s_axis_tdata;
  logic                 rsp_err, m_axis_tvalid, m_axis_tready;
  logic                 s_axis_tvalid, s_axis_tready, busy, stat_rx_stray;

  spi_reg_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_rw        (req_rw),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .busy          (busy),
    .stat_rx_stray (stat_rx_stray)
  );

  // ---------------- SPI master model + monitor ----------------
  logic [7:0] miso_byte = 8'h00;
  bit         spi_connected = 1'b1;
  int         stray_req = 0, stray_ack = 0;
  int         cyc = 0, last_tx_cyc = 0, last_rsp_cyc = 0, drop_cnt = 0;
  int         rsp_cnt [NUM_REQ];
  logic [7:0] mosi_log [$];
  int         grant_log [$];
  logic [7:0] rx_data_q [$];
  int         rx_time_q [$];
  bit         tx_idx = 1'b0, in_gap = 1'b0;

  initial for (int i = 0; i < NUM_REQ; i++) rsp_cnt[i] = 0;

  always begin
    @(posedge aclk);
    if (!aresetn) begin
      rx_data_q.delete();
      rx_time_q.delete();
      tx_idx = 1'b0;
      in_gap = 1'b0;
    end else begin
      if (m_axis_tvalid && m_axis_tready) begin
        mosi_log.push_back(m_axis_tdata);
        last_tx_cyc = cyc;
        if (spi_connected) begin
          rx_data_q.push_back(tx_idx ? miso_byte : 8'h5A);
          rx_time_q.push_back(cyc + 6);
        end
        in_gap = !tx_idx;
        tx_idx = !tx_idx;
      end else if (in_gap && !m_axis_tvalid) begin
        drop_cnt++;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rsp_valid[i]) rsp_cnt[i]++;
        if (req_valid[i] && req_ready[i]) grant_log.push_back(i);
      end
      if (|rsp_valid) last_rsp_cyc = cyc;
    end
    cyc++;
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 8'h00;
    if (stray_req != stray_ack) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 8'h77;
      stray_ack++;
    end else if (rx_data_q.size() > 0 && rx_time_q[0] <= cyc) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = rx_data_q.pop_front();
      void'(rx_time_q.pop_front());
    end
  end

  // ---------------- scoreboard helpers ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_bound(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  task automatic tick();
    @(negedge aclk);
    #1;
  endtask

  function automatic int rsp_total();
    int s = 0;
    for (int i = 0; i < NUM_REQ; i++) s += rsp_cnt[i];
    return s;
  endfunction

  // ---------------- driver ----------------
  task automatic do_txn(input int idx, input logic rw, input logic [6:0] addr,
                        input logic [7:0] wd, output logic [NUM_REQ-1:0] rv,
                        output logic [7:0] rd, output logic er);
    int n;
    rv = '0; rd = '0; er = 1'b0;
    tick();
    req_rw[idx]            = rw;
    req_addr[7*idx +: 7]   = addr;
    req_wdata[8*idx +: 8]  = wd;
    req_valid[idx]         = 1'b1;
    #1;
    n = 0;
    while (!req_ready[idx] && n < 200) begin tick(); n++; end
    if (!req_ready[idx]) begin
      fail_bound("grant_wait");
      req_valid[idx] = 1'b0;
      return;
    end
    tick();
    req_valid[idx] = 1'b0;
    n = 0;
    while (rsp_valid == '0 && n < 3000) begin tick(); n++; end
    if (rsp_valid == '0) begin
      fail_bound("rsp_wait");
      return;
    end
    rv = rsp_valid; rd = rsp_rdata; er = rsp_err;
  endtask

  task automatic apply_reset();
    tick();
    req_valid     = '0;
    m_axis_tready = 1'b1;
    aresetn       = 1'b0;
    repeat (3) tick();
    aresetn = 1'b1;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    int         idx;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] miso;
    logic [7:0] mosi0;
    logic [7:0] mosi1;
    logic [7:0] rdata;
  } vec_t;

  vec_t vecs [6];

  logic [NUM_REQ-1:0] rv;
  logic [7:0]         rd;
  logic               er;
  int                 mbase, gbase, n, snap;
  int                 cnt_snap [NUM_REQ];

  initial begin
    vecs[0] = '{idx: 1, rw: 1'b1, addr: 7'h15, wdata: 8'h00, miso: 8'hA5, mosi0: 8'h95, mosi1: 8'h00, rdata: 8'hA5};
    vecs[1] = '{idx: 0, rw: 1'b0, addr: 7'h7F, wdata: 8'h3C, miso: 8'h00, mosi0: 8'h7F, mosi1: 8'h3C, rdata: 8'h00};
    vecs[2] = '{idx: 3, rw: 1'b1, addr: 7'h00, wdata: 8'h99, miso: 8'h5C, mosi0: 8'h80, mosi1: 8'h00, rdata: 8'h5C};
    vecs[3] = '{idx: 2, rw: 1'b0, addr: 7'h2A, wdata: 8'hFF, miso: 8'h11, mosi0: 8'h2A, mosi1: 8'hFF, rdata: 8'h11};
    vecs[4] = '{idx: 0, rw: 1'b1, addr: 7'h7F, wdata: 8'h00, miso: 8'h00, mosi0: 8'hFF, mosi1: 8'h00, rdata: 8'h00};
    vecs[5] = '{idx: 1, rw: 1'b0, addr: 7'h01, wdata: 8'h00, miso: 8'hE7, mosi0: 8'h01, mosi1: 8'h00, rdata: 8'hE7};

    req_valid = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
    m_axis_tready = 1'b1;
    aresetn = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_m_tdata", m_axis_tdata, 0);
    check("rst_s_tready", s_axis_tready, 1);
    check("rst_busy", busy, 0);
    check("rst_stray", stat_rx_stray, 0);
    aresetn = 1'b1;

    // Table-driven single transactions
    for (int v = 0; v < 6; v++) begin
      miso_byte = vecs[v].miso;
      mbase = mosi_log.size();
      exp_q.push_back(vecs[v].mosi0);
      exp_q.push_back(vecs[v].mosi1);
      do_txn(vecs[v].idx, vecs[v].rw, vecs[v].addr, vecs[v].wdata, rv, rd, er);
      check($sformatf("v%0d_rsp_valid", v), rv, 32'(1) << vecs[v].idx);
      check($sformatf("v%0d_rdata", v), rd, vecs[v].rdata);
      check($sformatf("v%0d_err", v), er, 0);
      tick();
      check($sformatf("v%0d_rsp_pulse", v), rsp_valid, 0);
      check($sformatf("v%0d_busy_after", v), busy, 0);
      check($sformatf("v%0d_mosi_count", v), mosi_log.size() - mbase, 2);
      for (int b = 0; b < 2; b++) begin
        if (mosi_log.size() > mbase + b)
          check($sformatf("v%0d_mosi%0d", v, b), mosi_log[mbase+b], exp_q.pop_front());
        else
          void'(exp_q.pop_front());
      end
    end

    // RX timeout: model disconnected from s_axis
    spi_connected = 1'b0;
    do_txn(2, 1'b1, 7'h10, 8'h00, rv, rd, er);
    tick();
    check("to_rsp_valid", rv, 4'b0100);
    check("to_rdata", rd, 8'hFF);
    check("to_err", er, 1);
    check("to_latency", last_rsp_cyc - last_tx_cyc, TIMEOUT + 1);
    check("to_busy_after", busy, 0);
    spi_connected = 1'b1;

    // Recovery after timeout
    miso_byte = 8'h3E;
    do_txn(3, 1'b1, 7'h22, 8'h00, rv, rd, er);
    check("rec_rsp_valid", rv, 4'b1000);
    check("rec_rdata", rd, 8'h3E);
    check("rec_err", er, 0);
    tick();

    // Stray RX byte while idle
    snap = rsp_total();
    @(posedge aclk);
    #1 stray_req++;
    tick();
    tick();
    check("stray_pulse", stat_rx_stray, 1);
    tick();
    check("stray_single", stat_rx_stray, 0);
    check("stray_busy", busy, 0);
    check("stray_no_rsp", rsp_total() - snap, 0);

    // Reset during S_TX1
    snap = rsp_total();
    m_axis_tready = 1'b0;
    req_rw[2] = 1'b0; req_addr[14 +: 7] = 7'h33; req_wdata[16 +: 8] = 8'hC4;
    req_valid[2] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[2] && n < 200) begin tick(); n++; end
    if (!req_ready[2]) fail_bound("mid_grant_wait");
    tick();
    req_valid[2] = 1'b0;
    m_axis_tready = 1'b1;
    tick();
    m_axis_tready = 1'b0;
    check("mid_tx1_data", m_axis_tdata, 8'hC4);
    check("mid_busy", busy, 1);
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    m_axis_tready = 1'b1;
    check("mid_busy_rst", busy, 0);
    check("mid_tvalid_rst", m_axis_tvalid, 0);
    repeat (10) tick();
    check("mid_no_rsp", rsp_total() - snap, 0);
    req_valid[1] = 1'b1;
    req_valid[3] = 1'b1;
    #1;
    check("mid_next_grant", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    n = 0;
    while (busy && n < 200) begin tick(); n++; end
    if (busy) fail_bound("mid_done_wait");
    check("mid_grant_log", grant_log[grant_log.size()-1], 1);
    repeat (3) tick();

    // Fairness: all requesters continuously valid for 8 frames
    apply_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_rw[i] = 1'b0;
      req_addr[7*i +: 7] = 7'(i);
      req_wdata[8*i +: 8] = 8'(i);
      cnt_snap[i] = rsp_cnt[i];
    end
    gbase = grant_log.size();
    req_valid = '1;
    n = 0;
    while (grant_log.size() < gbase + 8 && n < 1000) begin tick(); n++; end
    req_valid = '0;
    if (grant_log.size() < gbase + 8) fail_bound("rr_grant_wait");
    n = 0;
    while (busy && n < 200) begin tick(); n++; end
    if (busy) fail_bound("rr_done_wait");
    tick();
    for (int k = 0; k < 8; k++)
      if (grant_log.size() > gbase + k)
        check($sformatf("rr_order%0d", k), grant_log[gbase+k], k % NUM_REQ);
    for (int i = 0; i < NUM_REQ; i++)
      check($sformatf("rr_rsp_cnt%0d", i), rsp_cnt[i] - cnt_snap[i], 2);

    check("tvalid_gap_drops", drop_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
